// File: rtl/nn_punto_fijo_pkg.sv
// Shared fixed-point constants and FSM encoding for the neuron MAC sequencer.
package nn_punto_fijo_pkg;

    localparam int unsigned WIDTH     = 24;
    localparam int unsigned MAGNITUD  = 4;
    localparam int unsigned PRECISION = 19;
    localparam int unsigned SIGNO     = 1;

    localparam logic signed [WIDTH-1:0] Q_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] Q_MIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] Q_ONE =
        {{(WIDTH-PRECISION-1){1'b0}}, 1'b1, {PRECISION{1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PRIME = 2'd1;
    localparam logic [1:0] S_MAC   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/neurona_mac_secuenciador_if.sv
// Bundle of controller, memory and multiplier signals around one neuron sequencer.
interface neurona_mac_secuenciador_if #(
    parameter int unsigned Width   = nn_punto_fijo_pkg::WIDTH,
    parameter int unsigned NInputs = 8
);
    localparam int unsigned AW = $clog2(NInputs);

    logic              start;
    logic [Width-1:0]  bias_in;
    logic [AW-1:0]     mem_addr;
    logic [Width-1:0]  In_data;
    logic [Width-1:0]  Coeff_data;
    logic              mul_en;
    logic [Width-1:0]  mul_a;
    logic [Width-1:0]  mul_b;
    logic [Width-1:0]  mul_out;
    logic              mul_err;
    logic              busy;
    logic              done;
    logic [Width-1:0]  result_out;
    logic              err_out;

    // sequencer side
    modport slave (
        input  start, bias_in, In_data, Coeff_data, mul_out, mul_err,
        output mem_addr, mul_en, mul_a, mul_b, busy, done, result_out, err_out
    );

    // layer controller, memories and multiplier side
    modport master (
        output start, bias_in, In_data, Coeff_data, mul_out, mul_err,
        input  mem_addr, mul_en, mul_a, mul_b, busy, done, result_out, err_out
    );

endinterface

// File: rtl/sumador_saturado.sv
// Two's complement adder that clamps to the representable range and flags the clamp.
module sumador_saturado
    import nn_punto_fijo_pkg::*;
#(
    parameter int unsigned Width = WIDTH
) (
    input  logic signed [Width-1:0] a,
    input  logic signed [Width-1:0] b,
    output logic signed [Width-1:0] sum_c,
    output logic                    sat_c
);

    localparam logic [Width-1:0] SAT_MAX = {1'b0, {(Width-1){1'b1}}};
    localparam logic [Width-1:0] SAT_MIN = {1'b1, {(Width-1){1'b0}}};

    logic [Width:0] full;

    // one guard bit: overflow shows up as guard != sign
    always_comb begin
        full  = {a[Width-1], a} + {b[Width-1], b};
        sat_c = full[Width] ^ full[Width-1];
        sum_c = full[Width-1:0];
        if (sat_c) begin
            sum_c = full[Width] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/neurona_mac_secuenciador.sv
// Neuron evaluation sequencer: bias + sum of NInputs products with saturation.
// Optional NEURONA_RELU_EN: clamp negative results to zero on the output register.
module neurona_mac_secuenciador
    import nn_punto_fijo_pkg::*;
#(
    parameter int unsigned Width     = WIDTH,
    parameter int unsigned Magnitud  = MAGNITUD,
    parameter int unsigned Precision = PRECISION,
    parameter int unsigned Signo     = SIGNO,
    parameter int unsigned NInputs   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    neurona_mac_secuenciador_if.slave   bus
);

    localparam int unsigned AW = $clog2(NInputs);
    localparam int unsigned IW = AW + 1;
    // accumulator width follows the Q format, which matches the bus word
    localparam int unsigned QW = Signo + Magnitud + Precision;

    localparam logic [IW-1:0] IDX_LAST  = IW'(NInputs);
    localparam logic [AW-1:0] ADDR_LAST = AW'(NInputs - 1);

    logic [1:0]           state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic signed [QW-1:0] acc_q, acc_d;
    logic                 err_q, err_d;
    logic [Width-1:0]     result_q, result_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic                 mul_en_q, mul_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic signed [QW-1:0] sum_c;
    logic                 sat_c;
    logic [QW-1:0]        final_c;

    sumador_saturado #(
        .Width (QW)
    ) u_sumador (
        .a     (acc_q),
        .b     (QW'(bus.mul_out)),
        .sum_c (sum_c),
        .sat_c (sat_c)
    );

`ifdef NEURONA_RELU_EN
    assign final_c = sum_c[QW-1] ? '0 : sum_c;
`else
    assign final_c = sum_c;
`endif

    // next state, datapath and next registered outputs
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        err_d    = err_q;
        result_d = result_q;
        addr_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_PRIME;
                    acc_d   = QW'(bus.bias_in);
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_PRIME: begin
                state_d = S_MAC;
                idx_d   = IW'(1);
            end
            S_MAC: begin
                // data on the bus now belongs to element idx-1
                acc_d = sum_c;
                err_d = err_q | bus.mul_err | sat_c;
                if (idx_q == IDX_LAST) begin
                    state_d  = S_DONE;
                    result_d = Width'(final_c);
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_MAC) begin
            addr_d = (idx_d < IDX_LAST) ? idx_d[AW-1:0] : ADDR_LAST;
        end
        mul_en_d = (state_d == S_MAC);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
            addr_q   <= '0;
            mul_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            err_q    <= err_d;
            result_q <= result_d;
            addr_q   <= addr_d;
            mul_en_q <= mul_en_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mul_en     = mul_en_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result_out = result_q;
    assign bus.err_out    = err_q;

    // memory words go straight to the shared multiplier
    assign bus.mul_a = bus.In_data;
    assign bus.mul_b = bus.Coeff_data;

endmodule

// File: tb/tb_neurona_mac_secuenciador.sv
// Bench for neurona_mac_secuenciador with NInputs=4, Q4.19 words, memory and multiplier models.
module tb_neurona_mac_secuenciador;
    import nn_punto_fijo_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned W  = 24;
    localparam int unsigned P  = 19;
    localparam longint QMAXL = 64'sd8388607;
    localparam longint QMINL = -64'sd8388608;

    typedef struct {
        string          name;
        logic [W-1:0]   in_v;
        logic [W-1:0]   co_v;
        logic [W-1:0]   bias;
        logic [W-1:0]   exp_res;
        logic           exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neurona_mac_secuenciador_if #(.Width(W), .NInputs(N)) bus ();

    neurona_mac_secuenciador #(
        .Width(W), .Magnitud(4), .Precision(P), .Signo(1), .NInputs(N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W-1:0] in_mem [N];
    logic [W-1:0] co_mem [N];

    int n_chk  = 0;
    int n_fail = 0;

    // Q4.19 multiplier: full product rescaled, saturated, error on saturation
    function automatic logic [W:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = p >>> P;
        if (p > QMAXL) return {1'b1, W'(QMAXL)};
        if (p < QMINL) return {1'b1, W'(QMINL)};
        return {1'b0, W'(p)};
    endfunction

    // expected {err, result} for the words currently in the memories
    function automatic logic [W:0] ref_neuron(input logic [W-1:0] b);
        longint     acc;
        logic       e;
        logic [W:0] m;
        acc = longint'($signed(b));
        e   = 1'b0;
        for (int i = 0; i < N; i++) begin
            m   = mul_model(in_mem[i], co_mem[i]);
            e   = e | m[W];
            acc = acc + longint'($signed(m[W-1:0]));
            if (acc > QMAXL) begin acc = QMAXL; e = 1'b1; end
            if (acc < QMINL) begin acc = QMINL; e = 1'b1; end
        end
`ifdef NEURONA_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return {e, W'(acc)};
    endfunction

    assign {bus.mul_err, bus.mul_out} = mul_model(bus.mul_a, bus.mul_b);

    always @(posedge clk) begin
        bus.In_data    <= in_mem[bus.mem_addr];
        bus.Coeff_data <= co_mem[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill(input logic [W-1:0] iv, input logic [W-1:0] cv);
        for (int i = 0; i < N; i++) begin
            in_mem[i] = iv;
            co_mem[i] = cv;
        end
    endtask

    function automatic logic [W-1:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return W'($urandom);
        return W'(int'($urandom_range(0, 4 * 524288)) - 2 * 524288);
    endfunction

    // call #1 after a rising edge with the sequencer idle; returns in the done cycle
    task automatic run(input logic [W-1:0] b, input int mid, output logic [W-1:0] res,
                       output logic e, output int lat);
        int cyc;
        int exp_addr;
        bus.bias_in = b;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        bus.start = (cyc == mid);
        chk("prime_busy", 32'(bus.busy), 32'd1);
        chk("prime_mul_en", 32'(bus.mul_en), 32'd0);
        chk("prime_err_clear", 32'(bus.err_out), 32'd0);
        chk("prime_addr", 32'(bus.mem_addr), 32'd0);
        while (!bus.done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            bus.start = (cyc == mid);
            if (cyc >= 2 && cyc <= N + 1) begin
                exp_addr = (cyc - 1 < N) ? cyc - 1 : N - 1;
                chk("mac_addr", 32'(bus.mem_addr), 32'(exp_addr));
                chk("mac_mul_en", 32'(bus.mul_en), 32'd1);
            end
        end
        bus.start = 1'b0;
        res = bus.result_out;
        e   = bus.err_out;
        lat = bus.done ? cyc : -1;
        if (!bus.done) $display("FAIL done_timeout: no done within %0d cycles", cyc);
    endtask

    vec_t         vecs [5];
    logic [W-1:0] res;
    logic         e;
    int           lat;
    int           dones;
    logic [W:0]   expv;
    logic [W-1:0] b;

    initial begin
        vecs[0] = '{"t1_unit", 24'h080000, 24'h040000, 24'h000000, 24'h100000, 1'b0};
        vecs[1] = '{"t2_mulsat", 24'h3C0000, 24'h3C0000, 24'h000000, 24'h7FFFFF, 1'b1};
`ifdef NEURONA_RELU_EN
        vecs[2] = '{"t3_neg", 24'h080000, 24'hF80000, 24'hF80000, 24'h000000, 1'b0};
        vecs[3] = '{"negsat", 24'hC00000, 24'h080000, 24'h000000, 24'h000000, 1'b1};
`else
        vecs[2] = '{"t3_neg", 24'h080000, 24'hF80000, 24'hF80000, 24'hD80000, 1'b0};
        vecs[3] = '{"negsat", 24'hC00000, 24'h080000, 24'h000000, 24'h800000, 1'b1};
`endif
        vecs[4] = '{"t6_sumsat", 24'h180000, 24'h080000, 24'h200000, 24'h7FFFFF, 1'b1};

        fill('0, '0);
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.bias_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mul_en", 32'(bus.mul_en), 32'd0);
        chk("rst_err", 32'(bus.err_out), 32'd0);
        chk("rst_result", 32'(bus.result_out), 32'd0);
        chk("rst_addr", 32'(bus.mem_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            fill(vecs[v].in_v, vecs[v].co_v);
            run(vecs[v].bias, 0, res, e, lat);
            chk({vecs[v].name, "_latency"}, 32'(lat), 32'(N + 2));
            chk({vecs[v].name, "_result"}, 32'(res), 32'(vecs[v].exp_res));
            chk({vecs[v].name, "_err"}, 32'(e), 32'(vecs[v].exp_err));
            @(posedge clk); #1;
            chk({vecs[v].name, "_done_pulse"}, 32'(bus.done), 32'd0);
            chk({vecs[v].name, "_idle"}, 32'(bus.busy), 32'd0);
            chk({vecs[v].name, "_hold"}, 32'(bus.result_out), 32'(vecs[v].exp_res));
        end

        // back-to-back: error run, then restart the cycle right after done
        fill(24'h3C0000, 24'h3C0000);
        run(24'h000000, 0, res, e, lat);
        chk("b2b_first_err", 32'(e), 32'd1);
        fill(24'h080000, 24'h040000);
        @(posedge clk); #1;
        chk("b2b_err_held", 32'(bus.err_out), 32'd1);
        run(24'h000000, 0, res, e, lat);
        chk("b2b_latency", 32'(lat), 32'(N + 2));
        chk("b2b_result", 32'(res), 32'h100000);
        chk("b2b_err", 32'(e), 32'd0);
        @(posedge clk); #1;

        // start pulsed during MAC must not queue a second evaluation
        run(24'h000000, 3, res, e, lat);
        chk("midstart_latency", 32'(lat), 32'(N + 2));
        chk("midstart_result", 32'(res), 32'h100000);
        dones = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("midstart_single_done", 32'(dones), 32'd0);

        // reset in the second MAC cycle
        bus.bias_in = 24'h080000;
        bus.start   = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_mac", 32'(bus.mul_en), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_result", 32'(bus.result_out), 32'd0);
        chk("abort_mul_en", 32'(bus.mul_en), 32'd0);
        chk("abort_addr", 32'(bus.mem_addr), 32'd0);
        dones = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);

        // randomized evaluations against the reference model
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                in_mem[i] = rnd_word();
                co_mem[i] = rnd_word();
            end
            b    = rnd_word();
            expv = ref_neuron(b);
            run(b, 0, res, e, lat);
            chk("rand_latency", 32'(lat), 32'(N + 2));
            chk("rand_result", 32'(res), 32'(expv[W-1:0]));
            chk("rand_err", 32'(e), 32'(expv[W]));
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
